// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder. The ovf signal exists only when
// SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice per clock, LSB first.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  io
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               bit_s, bit_c, last;

  // The single full-adder slice.
  assign bit_s = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
  assign bit_c = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);
  assign last  = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.start) state_d = RUN;
      RUN:     if (last)     state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Start is only looked at in IDLE, so a request during RUN leaves no trace.
  always_comb begin
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.start) begin
          sh_a_d  = io.a;
          sh_b_d  = io.b;
          carry_d = io.cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        acc_d   = {bit_s, acc_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          sum_d  = {bit_s, acc_q[WIDTH-1:1]};
          cout_d = bit_c;
          done_d = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB slice on the last edge.
          ovf_d  = carry_q ^ bit_c;
`endif
        end
      end
      default: ;
    endcase
    busy_d = (state_d == RUN);
  end

  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.sum  = sum_q;
  assign io.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign io.ovf  = ovf_q;
`endif

endmodule
